adder_seq_word: RTL and testbench
=================================

ADDER_SEQ_WORD -- requirements
Module: adder_seq_word

Interface
REQ-001 Parameter: NBYTES, 4, number of 8-bit slices per operand; data width W = 8*NBYTES.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand transfer request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_cin  input  1  carry-in.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  W  sum A+B+cin, modulo 2^W.
REQ-013 out_cout  output  1  unsigned carry-out of bit W-1.
REQ-014 out_ovf  output  1  two's-complement overflow.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid & in_ready, operands SHALL be latched, the carry register SHALL load in_cin, slice index SHALL clear to 0, and the FSM SHALL go to RUN.
REQ-019 RUN: each cycle, slice idx of latched A and B plus the carry register SHALL pass through one 8-bit adder; the 8-bit result SHALL be written to sum byte idx; carry SHALL take the adder carry-out; idx SHALL increment.
REQ-020 RUN -> DONE when the slice with idx = NBYTES-1 is processed; idx SHALL NOT wrap into a further RUN cycle.
REQ-021 Latency: operands accepted at edge T; RUN occupies cycles T+1..T+NBYTES; out_valid SHALL be high from cycle T+NBYTES+1.
REQ-022 out_cout SHALL equal the final carry register; out_ovf SHALL be (A[W-1]==B[W-1]) & (sum[W-1]!=A[W-1]).
REQ-023 DONE: out_sum, out_cout and out_ovf SHALL stay stable while out_valid & !out_ready.
REQ-024 DONE -> IDLE on out_valid & out_ready; outputs SHALL keep their values until the next result overwrites them.
REQ-025 in_valid in RUN or DONE SHALL be ignored (no accept, no state change); minimum transaction spacing is NBYTES+2 cycles.
REQ-026 in_a, in_b and in_cin changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-027 While rst is high: state IDLE, idx 0, carry 0, out_sum 0, out_cout 0, out_ovf 0, out_valid 0, busy 0, in_ready 0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the transaction with no partial result visible; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package SHALL hold the slice width (8), the NBYTES default, and the state enumeration type.
REQ-030 The slice adder SHALL be one instance of the team's existing combinational 8-bit carry-lookahead adder (adder8); no other sub-module is used.
REQ-031 Carry and index registers SHALL be the only state besides the operand, sum and FSM registers.

Verification
REQ-032 A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum 0x00000000, cout 1, ovf 0, out_valid first high 5 cycles after accept.
REQ-033 A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum 0x80000000, cout 0, ovf 1.
REQ-034 Backpressure: out_ready low for 3 cycles after out_valid rises -> sum/flags constant, in_ready 0 throughout, IDLE one cycle after out_ready=1.
REQ-035 rst pulse two cycles into RUN -> all outputs 0; next A=0x12345678, B=0x11111111, cin=1 -> sum 0x2345678A, cout 0, ovf 0.
REQ-036 in_valid held high continuously with changing operands -> accepts exactly every 6 cycles; each result matches operands sampled at its accept.
REQ-037 1000 random transactions with random out_ready stalls -> every {cout,sum} equals A+B+cin from a reference model.

Source files
------------

// File: rtl/adder_seq_word_pkg.sv
// Shared constants and FSM state type for the byte-serial word adder.
package adder_seq_word_pkg;

    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder8.sv
// Combinational 8-bit carry-lookahead adder: every carry is expanded
// directly from generate/propagate terms rather than rippled.
module adder8
    import adder_seq_word_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;
    logic               w_run;
    logic               w_prop;

    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c    = '0;
        w_run  = 1'b0;
        w_prop = 1'b0;
        w_c[0] = i_cin;
        // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            w_run  = w_g[i];
            w_prop = w_p[i];
            for (int unsigned j = i; j > 0; j--) begin
                w_run  = w_run | (w_prop & w_g[j-1]);
                w_prop = w_prop & w_p[j-1];
            end
            w_c[i+1] = w_run | (w_prop & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
    assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/adder_seq_word.sv
// Word adder that processes one 8-bit slice per cycle through a single
// adder8, with valid/ready handshakes on both operand and result sides.
module adder_seq_word
    import adder_seq_word_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NBYTES-1:0] in_a,
    input  logic [SLICE_W*NBYTES-1:0] in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NBYTES-1:0] out_sum,
    output logic                      out_cout,
    output logic                      out_ovf,
    output logic                      busy
);

    localparam int unsigned W        = SLICE_W * NBYTES;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [31:0]        w_base;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_ss;
    logic               w_co;
    logic               w_accept;
    logic               w_last;

    assign w_base   = 32'(r_idx) * SLICE_W;
    assign w_sa     = r_a[w_base +: SLICE_W];
    assign w_sb     = r_b[w_base +: SLICE_W];
    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = in_valid & in_ready;

    adder8 u_adder8 (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_sum  (w_ss),
        .o_cout (w_co)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_ss;
                    r_carry                  <= w_co;
                    // Index parks on the last slice; the FSM leaves RUN here.
                    if (!w_last) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
    assign out_ovf   = (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);

endmodule

// File: tb/tb_adder_seq_word.sv
// Self-checking bench: reference model of A+B+cin in plain arithmetic plus
// directed literal cases, latency, backpressure, reset and spacing checks.
module tb_adder_seq_word;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    always #5 clk = ~clk;

    adder_seq_word #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } txn_t;

    txn_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    int   n_acc    = 0;
    int   prev_acc = 0;
    bit   have_prev = 0;
    bit   cont_mode = 0;
    bit   rnd_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input txn_t t);
        logic [W:0] u;
        longint     s;
        logic       ovf;
        u   = {1'b0, t.a} + {1'b0, t.b} + (W+1)'(t.cin);
        s   = longint'($signed(t.a)) + longint'($signed(t.b)) + longint'(t.cin);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {ovf, u};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [W+1:0] e;
        txn_t t;
        if (rst) begin
            chk("rst_sum", out_sum, 0);
            chk("rst_cout", out_cout, 0);
            chk("rst_ovf", out_ovf, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            q.delete();
        end else begin
            if (q.size() == 0) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_out_valid", out_valid, 0);
            end else begin
                chk("inflight_in_ready", in_ready, 0);
                chk("inflight_busy", busy, 1);
                if (out_valid) begin
                    e = model(q[0]);
                    chk("sum", out_sum, e[W-1:0]);
                    chk("cout", out_cout, e[W]);
                    chk("ovf", out_ovf, e[W+1]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_done++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                t.a = in_a; t.b = in_b; t.cin = in_cin;
                q.push_back(t);
                n_acc++;
                if (cont_mode && have_prev) chk("accept_spacing", cyc - prev_acc, NB + 2);
                prev_acc  = cyc;
                have_prev = 1;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        n = 0;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 200) break;
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom % 3) != 0;
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
        if (rnd_ready) out_ready = ($urandom % 3) != 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom % 8)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Carry through every slice, and first-valid latency.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(n);
        chk("latency", n, NB + 1);
        chk("ffff_sum", out_sum, 32'h0000_0000);
        chk("ffff_cout", out_cout, 1);
        chk("ffff_ovf", out_ovf, 0);

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(n);
        chk("ovf_sum", out_sum, 32'h8000_0000);
        chk("ovf_cout", out_cout, 0);
        chk("ovf_ovf", out_ovf, 1);

        // Backpressure: result holds while out_ready is low.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        wait_valid(n);
        repeat (3) begin
            @(negedge clk);
            chk("bp_sum", out_sum, 32'h1010_1010);
            chk("bp_cout", out_cout, 0);
            chk("bp_ovf", out_ovf, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_busy", busy, 0);

        // Reset in the middle of RUN.
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_sum", out_sum, 0);
        chk("abort_valid", out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        send(32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_valid(n);
        chk("post_rst_sum", out_sum, 32'h2345_678A);
        chk("post_rst_cout", out_cout, 0);
        chk("post_rst_ovf", out_ovf, 0);

        // in_valid held high with operands changing every cycle.
        @(posedge clk); #1;
        base      = n_acc;
        cont_mode = 1;
        have_prev = 0;
        in_valid  = 1'b1;
        repeat (60) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        cont_mode = 0;
        chk("cont_accepts", (n_acc - base) >= 9, 1);

        // Random transactions with random result stalls.
        base      = n_done + q.size();
        rnd_ready = 1;
        for (int i = 0; i < 1000; i++) send(rnd_word(), rnd_word(), 1'($urandom));
        rnd_ready = 0;
        @(posedge clk); #1 out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        chk("random_done", n_done - base, 1000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
